packed_dual_mul_pipe: RTL and testbench
=======================================

Name: packed_dual_mul_pipe

Overview:
- Pipelined successor to the packed dual multipliers. Two DATA_W-bit operands share one unsigned COEF_W-bit coefficient, and both products come from a single wide multiplier using guard-band packing.
- Adds what the combinational versions lack: width parameters, a per-transaction signed/unsigned mode, a 3-stage pipeline and valid/ready backpressure.
- Sits between the coefficient/sample fetch logic and the accumulate stage of the filter datapath.

Parameters:
- DATA_W, 12, width of each data operand a0/a1.
- COEF_W, 11, width of the shared unsigned coefficient.
- PROD_W, DATA_W+COEF_W, width of each product. Derived; must not be overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept an input this cycle.
- in_signed  in  1  1 = a0/a1 are two's complement; 0 = unsigned.
- in_a0  in  DATA_W  operand 0.
- in_a1  in  DATA_W  operand 1.
- in_coef  in  COEF_W  shared coefficient, always unsigned.
- out_valid  out  1  products valid.
- out_ready  in  1  downstream accepts.
- out_p0  out  PROD_W  a0*coef.
- out_p1  out  PROD_W  a1*coef.

Behaviour:
- Reset: rst_n low clears all stage valid bits asynchronously. out_valid=0, out_p0=0, out_p1=0, in_ready=1 one cycle after release. Data registers reset to 0.
- Transfer: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: 3 cycles from input transfer to out_valid with no backpressure. Throughput: 1 per cycle.
- Stage S1 (pack): register mode, coef and the packed operand P = {a0_raw, GUARD zero bits, a1_raw}, where GUARD = COEF_W. Raw fields are treated as unsigned.
- Stage S2 (multiply): register L = P*coef, unsigned, width 2*DATA_W+2*COEF_W.
  - Low field L[PROD_W-1:0] = a1_raw*coef.
  - High field = a0_raw*coef.
  - No carry crosses the guard band, by construction.
- Stage S3 (correct): if mode=1 and a operand MSB=1, subtract coef<<DATA_W from that field, mod 2^PROD_W.
  - Results must be bit-exact to the signed DATA_W x unsigned COEF_W product, PROD_W wide.
  - Unsigned mode applies no correction.
- Flow control, per stage k: advance_k = valid_k ? next-stage-ready : 1.
  - in_ready = !s1_valid | s2_can_accept.
  - Bubbles collapse, so no stall is inserted when a later stage is empty.
- A held output is stable: while out_valid & !out_ready, out_p0/out_p1 must not change.
- Simultaneous input and output transfer with a full pipe: both occur in the same cycle, with no lost or duplicated data.
- Mode, coef and operands travel with their transaction. Changing in_signed between transactions must not affect data already in flight.
- Reset mid-operation: all in-flight transactions are discarded and no out_valid follows reset release.
- Boundaries:
  - coef=0 gives 0.
  - Most-negative operand times maximum coef must be exact (see tests).
  - a=0 in signed mode applies no correction.

Decomposition:
- Package mul_pkg:
  - PROD_W, PACK_W and GUARD derivation functions.
  - Packed-operand struct (a0 field, guard, a1 field).
  - Stage-payload struct (valid, mode, coef, data).
- Sub-module packed_dual_mul_core: combinational pack, multiply, unpack and sign correction. Stage registers and handshake stay in the top.
- The core is reused by the unpipelined regression model.

Test Plan:
- Defaults, signed: a0=3, a1=0xFFB (-5), coef=7 -> after 3 cycles p0=0x000015, p1=0x7FFFDD.
- Signed extremes: a0=0x800, a1=0x7FF, coef=0x7FF -> p0=0x400800, p1=0x3FF001.
- Unsigned mode: a0=0x800, a1=0xFFF, coef=0x7FF -> p0=0x3FF800, p1=0x7FE801.
- Backpressure: stream 8 random transactions with out_ready held 0 for 5 cycles.
  - in_ready must drop after 3 accepted transactions.
  - Outputs must be held stable.
  - All 8 results must emerge in order, matching the reference model.
- Reset mid-stream: assert rst_n low with 3 transactions in flight -> out_valid=0 immediately. No output after release; the next transaction returns after exactly 3 cycles.
- Parameter sweep: DATA_W=8, COEF_W=8 and DATA_W=16, COEF_W=15, 10k random transactions in mixed mode with random ready -> bit-exact against signed/unsigned multiplication.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared definitions for the packed dual multiplier family.
//
// Purpose:
//   Width derivations for guard-band packing and the transaction mode type.
//   Two DATA_W operands share one COEF_W coefficient. They are packed as
//   {a0, GUARD zeros, a1} so that a single wide unsigned multiply yields both
//   products. GUARD = COEF_W is the least padding that stops the low product's
//   carry from reaching the high field.
//
//   The packed-operand and stage-payload structs depend on the DATA_W/COEF_W
//   parameters of each instance. A package cannot carry parameterised types,
//   so those structs are declared inside the modules that use them. They are
//   built from the widths derived here.
//
// Ports: none (package).
package mul_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  function automatic int prod_w(input int data_w, input int coef_w);
    return data_w + coef_w;
  endfunction

  function automatic int guard_w(input int coef_w);
    return coef_w;
  endfunction

  function automatic int pack_w(input int data_w, input int coef_w);
    return 2 * data_w + guard_w(coef_w);
  endfunction

endpackage

// File: rtl/packed_dual_mul_core.sv
// Combinational datapath of the packed dual multiplier.
//
// Purpose:
//   Provides three independent combinational slices: pack, multiply, and
//   unpack plus sign correction. A pipelined wrapper can register between the
//   slices, and an unpipelined model can simply chain them.
//
// Ports:
//   a0, a1          operands to pack (raw bits)
//   packed_op       {a0, GUARD zeros, a1}
//   mul_op          packed operand to multiply
//   mul_coef        shared unsigned coefficient
//   wide            mul_op * mul_coef, full width
//   fix_wide        wide product to unpack
//   fix_mode        signed/unsigned interpretation of the operands
//   fix_coef        coefficient used for the sign correction
//   fix_a0_msb/a1   operand sign bits
//   p0, p1          final PROD_W products a0*coef and a1*coef
module packed_dual_mul_core
  import mul_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = 11,
  localparam int PROD_W = prod_w(DATA_W, COEF_W),
  localparam int PACK_W = pack_w(DATA_W, COEF_W),
  localparam int GUARD  = guard_w(COEF_W),
  localparam int WIDE_W = 2 * PROD_W
) (
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  output logic [PACK_W-1:0] packed_op,
  input  logic [PACK_W-1:0] mul_op,
  input  logic [COEF_W-1:0] mul_coef,
  output logic [WIDE_W-1:0] wide,
  input  logic [WIDE_W-1:0] fix_wide,
  input  mode_e             fix_mode,
  input  logic [COEF_W-1:0] fix_coef,
  input  logic              fix_a0_msb,
  input  logic              fix_a1_msb,
  output logic [PROD_W-1:0] p0,
  output logic [PROD_W-1:0] p1
);

  logic [PROD_W-1:0] sign_fix;

  assign packed_op = {a0, {GUARD{1'b0}}, a1};

  // The guard band keeps a1*coef below 2^PROD_W, so the two fields never interact.
  assign wide = WIDE_W'(mul_op) * WIDE_W'(mul_coef);

  // A two's complement operand with its MSB set equals raw - 2^DATA_W.
  // Its product is therefore raw*coef - (coef << DATA_W), taken mod 2^PROD_W.
  assign sign_fix = {fix_coef, {DATA_W{1'b0}}};

  always_comb begin
    p0 = fix_wide[WIDE_W-1:PROD_W];
    p1 = fix_wide[PROD_W-1:0];
    if (fix_mode == MODE_SIGNED) begin
      if (fix_a0_msb) p0 = p0 - sign_fix;
      if (fix_a1_msb) p1 = p1 - sign_fix;
    end
  end

endmodule

// File: rtl/packed_dual_mul_pipe.sv
// Three-stage pipelined packed dual multiplier with valid/ready flow control.
//
// Purpose:
//   Computes a0*coef and a1*coef with one wide multiplier.
//   Stage 1 registers the packed operand, stage 2 registers the wide product,
//   and stage 3 registers the sign-corrected products.
//   Each stage advances when it is empty or when the stage after it can
//   accept, so bubbles collapse and a full pipe streams one result per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_signed           1 = operands are two's complement
//   in_a0, in_a1        DATA_W operands
//   in_coef             COEF_W unsigned coefficient
//   out_valid/out_ready output handshake
//   out_p0, out_p1      PROD_W products, held stable while stalled
module packed_dual_mul_pipe
  import mul_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int COEF_W = 11,
  localparam int PROD_W = prod_w(DATA_W, COEF_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_signed,
  input  logic [DATA_W-1:0] in_a0,
  input  logic [DATA_W-1:0] in_a1,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p0,
  output logic [PROD_W-1:0] out_p1
);

  localparam int PACK_W = pack_w(DATA_W, COEF_W);
  localparam int GUARD  = guard_w(COEF_W);
  localparam int WIDE_W = 2 * PROD_W;

  typedef struct packed {
    logic [DATA_W-1:0] a0;
    logic [GUARD-1:0]  guard;
    logic [DATA_W-1:0] a1;
  } pack_t;

  typedef struct packed {
    logic              valid;
    mode_e             mode;
    logic [COEF_W-1:0] coef;
    pack_t             data;
  } s1_t;

  typedef struct packed {
    logic              valid;
    mode_e             mode;
    logic [COEF_W-1:0] coef;
    logic              a0_msb;
    logic              a1_msb;
    logic [WIDE_W-1:0] data;
  } s2_t;

  s1_t s1;
  s2_t s2;
  logic s3_valid;
  logic s2_accept;
  logic s3_accept;

  logic [PACK_W-1:0] pack_next;
  logic [WIDE_W-1:0] wide_next;
  logic [PROD_W-1:0] p0_next;
  logic [PROD_W-1:0] p1_next;

  // Ready ripples back from the output so that an empty stage never blocks.
  assign s3_accept = !s3_valid || out_ready;
  assign s2_accept = !s2.valid || s3_accept;
  assign in_ready  = !s1.valid || s2_accept;
  assign out_valid = s3_valid;

  packed_dual_mul_core #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W)
  ) u_core (
    .a0        (in_a0),
    .a1        (in_a1),
    .packed_op (pack_next),
    .mul_op    (s1.data),
    .mul_coef  (s1.coef),
    .wide      (wide_next),
    .fix_wide  (s2.data),
    .fix_mode  (s2.mode),
    .fix_coef  (s2.coef),
    .fix_a0_msb(s2.a0_msb),
    .fix_a1_msb(s2.a1_msb),
    .p0        (p0_next),
    .p1        (p1_next)
  );

  // Payload registers load only on a real transfer.
  // A stalled or emptied stage therefore keeps its last data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else if (in_ready) begin
      s1.valid <= in_valid;
      if (in_valid) begin
        s1.mode <= mode_e'(in_signed);
        s1.coef <= in_coef;
        s1.data <= pack_next;
      end
    end
  end

  // The operand sign bits are carried alongside the product.
  // The packed operand itself is not kept after the multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2 <= '0;
    end else if (s2_accept) begin
      s2.valid <= s1.valid;
      if (s1.valid) begin
        s2.mode   <= s1.mode;
        s2.coef   <= s1.coef;
        s2.a0_msb <= s1.data.a0[DATA_W-1];
        s2.a1_msb <= s1.data.a1[DATA_W-1];
        s2.data   <= wide_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      out_p0   <= '0;
      out_p1   <= '0;
    end else if (s3_accept) begin
      s3_valid <= s2.valid;
      if (s2.valid) begin
        out_p0 <= p0_next;
        out_p1 <= p1_next;
      end
    end
  end

endmodule

// File: tb/tb_packed_dual_mul_pipe.sv
// Self-checking bench for packed_dual_mul_pipe.
//
// Purpose:
//   Drives directed vectors with hand-computed products into a default-width
//   instance, and checks every output transfer against a signed/unsigned
//   arithmetic reference.
//   Two further instances, at 8x8 and 16x15, stream random traffic with
//   random backpressure.
//
// Ports: none (top-level bench).
module tb_packed_dual_mul_pipe;

  localparam int DW = 12;
  localparam int CW = 11;
  localparam int PW = DW + CW;
  localparam int NSWEEP = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_sw_n;

  logic          in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [DW-1:0] in_a0, in_a1;
  logic [CW-1:0] in_coef;
  logic [PW-1:0] out_p0, out_p1;

  int vectors = 0;
  int miscompares = 0;

  packed_dual_mul_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a0(in_a0), .in_a1(in_a1), .in_coef(in_coef),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p0(out_p0), .out_p1(out_p1)
  );

  // 8x8 sweep instance
  logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
  logic [7:0]  a_in_a0, a_in_a1, a_in_coef;
  logic [15:0] a_out_p0, a_out_p1;

  packed_dual_mul_pipe #(.DATA_W(8), .COEF_W(8)) dut_a (
    .clk(clk), .rst_n(rst_sw_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_signed(a_in_signed),
    .in_a0(a_in_a0), .in_a1(a_in_a1), .in_coef(a_in_coef),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_p0(a_out_p0), .out_p1(a_out_p1)
  );

  // 16x15 sweep instance
  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [15:0] b_in_a0, b_in_a1;
  logic [14:0] b_in_coef;
  logic [30:0] b_out_p0, b_out_p1;

  packed_dual_mul_pipe #(.DATA_W(16), .COEF_W(15)) dut_b (
    .clk(clk), .rst_n(rst_sw_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_signed(b_in_signed),
    .in_a0(b_in_a0), .in_a1(b_in_a1), .in_coef(b_in_coef),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_p0(b_out_p0), .out_p1(b_out_p1)
  );

  // Reference: interpret the operand as signed or unsigned and multiply.
  // The result is reduced modulo 2^(dw+cw).
  function automatic longint refMul(input int dw, input int cw, input logic m,
                                    input longint a, input longint c);
    longint av;
    av = a;
    if (m && a[dw-1]) av = a - (longint'(1) << dw);
    return (av * c) & ((longint'(1) << (dw + cw)) - 1);
  endfunction

  logic [2*PW-1:0] mainQ[$];
  logic [31:0]     qA[$];
  logic [61:0]     qB[$];
  int accA = 0, accB = 0;
  logic doneA = 1'b0, doneB = 1'b0;

  // Main instance checker: ordering, values, spurious outputs and held-output stability.
  initial begin : mainMonitor
    logic          holdPend;
    logic [PW-1:0] holdP0, holdP1;
    logic [2*PW-1:0] exp;
    holdPend = 1'b0;
    holdP0 = '0;
    holdP1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mainQ.delete();
        holdPend = 1'b0;
      end else begin
        if (holdPend) begin
          vectors++;
          if (!out_valid || out_p0 != holdP0 || out_p1 != holdP1) begin
            miscompares++;
            $display("[TB] FAIL hold: got v=%0b p0=%h p1=%h, need v=1 p0=%h p1=%h",
                     out_valid, out_p0, out_p1, holdP0, holdP1);
          end
        end
        if (out_valid && mainQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL spurious: got out_valid=1 p0=%h p1=%h, need no output", out_p0, out_p1);
        end else if (out_valid && out_ready) begin
          exp = mainQ.pop_front();
          vectors++;
          if (out_p0 != exp[2*PW-1:PW] || out_p1 != exp[PW-1:0]) begin
            miscompares++;
            $display("[TB] FAIL model: got p0=%h p1=%h, need p0=%h p1=%h",
                     out_p0, out_p1, exp[2*PW-1:PW], exp[PW-1:0]);
          end
        end
        if (in_valid && in_ready)
          mainQ.push_back({PW'(refMul(DW, CW, in_signed, longint'(in_a0), longint'(in_coef))),
                           PW'(refMul(DW, CW, in_signed, longint'(in_a1), longint'(in_coef)))});
        holdPend = out_valid && !out_ready;
        holdP0 = out_p0;
        holdP1 = out_p1;
      end
    end
  end

  initial begin : monitorA
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst_sw_n) begin
        if (a_out_valid && a_out_ready) begin
          vectors++;
          if (qA.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL sweep8 spurious: got p0=%h p1=%h, need no output", a_out_p0, a_out_p1);
          end else begin
            exp = qA.pop_front();
            if (a_out_p0 != exp[31:16] || a_out_p1 != exp[15:0]) begin
              miscompares++;
              $display("[TB] FAIL sweep8: got p0=%h p1=%h, need p0=%h p1=%h",
                       a_out_p0, a_out_p1, exp[31:16], exp[15:0]);
            end
          end
        end
        if (a_in_valid && a_in_ready) begin
          qA.push_back({16'(refMul(8, 8, a_in_signed, longint'(a_in_a0), longint'(a_in_coef))),
                        16'(refMul(8, 8, a_in_signed, longint'(a_in_a1), longint'(a_in_coef)))});
          accA++;
        end
      end
    end
  end

  initial begin : monitorB
    logic [61:0] exp;
    forever begin
      @(negedge clk);
      if (rst_sw_n) begin
        if (b_out_valid && b_out_ready) begin
          vectors++;
          if (qB.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL sweep16 spurious: got p0=%h p1=%h, need no output", b_out_p0, b_out_p1);
          end else begin
            exp = qB.pop_front();
            if (b_out_p0 != exp[61:31] || b_out_p1 != exp[30:0]) begin
              miscompares++;
              $display("[TB] FAIL sweep16: got p0=%h p1=%h, need p0=%h p1=%h",
                       b_out_p0, b_out_p1, exp[61:31], exp[30:0]);
            end
          end
        end
        if (b_in_valid && b_in_ready) begin
          qB.push_back({31'(refMul(16, 15, b_in_signed, longint'(b_in_a0), longint'(b_in_coef))),
                        31'(refMul(16, 15, b_in_signed, longint'(b_in_a1), longint'(b_in_coef)))});
          accB++;
        end
      end
    end
  end

  initial begin : driveA
    int cyc;
    a_in_valid = 0; a_in_signed = 0; a_in_a0 = 0; a_in_a1 = 0; a_in_coef = 0; a_out_ready = 0;
    wait (rst_sw_n === 1'b1);
    @(posedge clk); #1;
    cyc = 0;
    while (accA < NSWEEP && cyc < 40000) begin
      a_in_valid  = ($urandom_range(0, 4) != 0);
      a_in_signed = 1'($urandom_range(0, 1));
      a_in_a0     = 8'($urandom);
      a_in_a1     = 8'($urandom);
      a_in_coef   = 8'($urandom);
      a_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    a_in_valid = 0;
    a_out_ready = 1;
    cyc = 0;
    while (qA.size() != 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    vectors++;
    if (qA.size() != 0 || accA < NSWEEP) begin
      miscompares++;
      $display("[TB] FAIL sweep8 drain: got accepted=%0d pending=%0d, need accepted=%0d pending=0",
               accA, qA.size(), NSWEEP);
    end
    doneA = 1'b1;
  end

  initial begin : driveB
    int cyc;
    b_in_valid = 0; b_in_signed = 0; b_in_a0 = 0; b_in_a1 = 0; b_in_coef = 0; b_out_ready = 0;
    wait (rst_sw_n === 1'b1);
    @(posedge clk); #1;
    cyc = 0;
    while (accB < NSWEEP && cyc < 40000) begin
      b_in_valid  = ($urandom_range(0, 4) != 0);
      b_in_signed = 1'($urandom_range(0, 1));
      b_in_a0     = 16'($urandom);
      b_in_a1     = 16'($urandom);
      b_in_coef   = 15'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    b_in_valid = 0;
    b_out_ready = 1;
    cyc = 0;
    while (qB.size() != 0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    vectors++;
    if (qB.size() != 0 || accB < NSWEEP) begin
      miscompares++;
      $display("[TB] FAIL sweep16 drain: got accepted=%0d pending=%0d, need accepted=%0d pending=0",
               accB, qB.size(), NSWEEP);
    end
    doneB = 1'b1;
  end

  // Presents one transaction and returns just after the edge that accepts it.
  // A following call keeps in_valid high with no gap.
  task automatic applyStimulus(input logic m, input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                               input logic [CW-1:0] c);
    int waitCnt;
    waitCnt = 0;
    in_valid = 1; in_signed = m; in_a0 = x0; in_a1 = x1; in_coef = c;
    @(negedge clk);
    while (!in_ready && waitCnt < 50) begin @(negedge clk); waitCnt++; end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept: got in_ready=0 after %0d cycles, need 1", waitCnt);
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  // Waits for the single in-flight result.
  // Checks both the 3-cycle latency and the literal products.
  task automatic checkOutput(input string name, input logic [PW-1:0] e0, input logic [PW-1:0] e1);
    int lat;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    vectors++;
    if (lat != 3 || out_p0 != e0 || out_p1 != e1) begin
      miscompares++;
      $display("[TB] FAIL %s: got lat=%0d p0=%h p1=%h, need lat=3 p0=%h p1=%h",
               name, lat, out_p0, out_p1, e0, e1);
    end
    @(posedge clk); #1;
  endtask

  logic          tMode[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [DW-1:0] tA0[6]   = '{12'h003, 12'h800, 12'h800, 12'hFFF, 12'h000, 12'hFFF};
  logic [DW-1:0] tA1[6]   = '{12'hFFB, 12'h7FF, 12'hFFF, 12'h800, 12'h800, 12'hFFF};
  logic [CW-1:0] tC[6]    = '{11'h007, 11'h7FF, 11'h7FF, 11'h000, 11'h7FF, 11'h7FF};
  logic [PW-1:0] tP0[6]   = '{23'h000015, 23'h400800, 23'h3FF800, 23'h000000, 23'h000000, 23'h7FE801};
  logic [PW-1:0] tP1[6]   = '{23'h7FFFDD, 23'h3FF001, 23'h7FE801, 23'h000000, 23'h400800, 23'h7FE801};
  string         tName[6] = '{"signed_small", "signed_extreme", "unsigned_extreme",
                              "coef_zero", "a0_zero_signed", "unsigned_max"};

  initial begin : mainSeq
    int cyc;
    rst_n = 0; rst_sw_n = 0;
    in_valid = 0; in_signed = 0; in_a0 = 0; in_a1 = 0; in_coef = 0; out_ready = 1;
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0 || out_p0 !== '0 || out_p1 !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got v=%b p0=%h p1=%h, need v=0 p0=0 p1=0", out_valid, out_p0, out_p1);
    end
    rst_n = 1; rst_sw_n = 1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got in_ready=%b out_valid=%b, need in_ready=1 out_valid=0",
               in_ready, out_valid);
    end

    $display("[TB] directed vectors");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tMode[i], tA0[i], tA1[i], tC[i]);
      checkOutput(tName[i], tP0[i], tP1[i]);
    end

    $display("[TB] back-to-back with alternating mode");
    for (int i = 0; i < 6; i++) applyStimulus(~tMode[i], tA0[i], tA1[i], tC[i]);
    for (int i = 0; i < 6; i++) applyStimulus(tMode[i], tA1[i], tA0[i], tC[i]);
    repeat (6) begin @(posedge clk); #1; end

    $display("[TB] backpressure");
    out_ready = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), CW'($urandom));
          if (i == 2) begin
            vectors++;
            if (in_ready !== 1'b0) begin
              miscompares++;
              $display("[TB] FAIL in_ready_full: got %b, need 0", in_ready);
            end
          end
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    cyc = 0;
    while (mainQ.size() != 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    vectors++;
    if (mainQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_drain: got %0d pending, need 0", mainQ.size());
    end

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) applyStimulus(tMode[i], tA0[i], tA1[i], tC[i]);
    rst_n = 0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flush: got out_valid=%b, need 0", out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL post_reset: got out_valid=%b, need 0", out_valid);
      end
    end
    @(posedge clk); #1;
    applyStimulus(1'b1, 12'h003, 12'hFFB, 11'h007);
    checkOutput("after_reset", 23'h000015, 23'h7FFFDD);

    cyc = 0;
    while (!(doneA && doneB) && cyc < 60000) begin @(posedge clk); cyc++; end
    if (!(doneA && doneB)) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL sweep_timeout: got doneA=%b doneB=%b, need both 1", doneA, doneB);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
